// File: rtl/addr_bus_responder.sv
// ============================================================================
// Module   : addr_bus_responder
// Purpose  : CPU address-bus target that decodes NES-style regions (mirrored
//            work RAM, I/O window, open bus, cartridge). It applies per-region
//            wait states and completes each access with a one-cycle ack.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module addr_bus_responder #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8,
   parameter int RAM_WAIT   = 0,
   parameter int IO_WAIT    = 2,
   parameter int CART_WAIT  = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [ADDR_WIDTH-1:0] addr_in,
   input  logic                  req,
   input  logic                  we,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  ack,
   output logic                  busy,
   output logic                  io_sel,
   output logic [2:0]            io_addr,
   output logic                  io_we,
   output logic [DATA_WIDTH-1:0] io_wdata,
   input  logic [DATA_WIDTH-1:0] io_rdata,
   output logic                  cart_sel,
   output logic [ADDR_WIDTH-1:0] cart_addr,
   output logic                  cart_we,
   output logic [DATA_WIDTH-1:0] cart_wdata,
   input  logic [DATA_WIDTH-1:0] cart_rdata
);

   localparam int c_CNT_W     = 8;
   localparam int c_RAM_AW    = 11;
   localparam int c_RAM_DEPTH = 1 << c_RAM_AW;

   localparam logic [c_CNT_W-1:0] c_RAM_WAIT  = c_CNT_W'(RAM_WAIT);
   localparam logic [c_CNT_W-1:0] c_IO_WAIT   = c_CNT_W'(IO_WAIT);
   localparam logic [c_CNT_W-1:0] c_CART_WAIT = c_CNT_W'(CART_WAIT);

   localparam logic [1:0] c_RGN_RAM  = 2'd0;
   localparam logic [1:0] c_RGN_IO   = 2'd1;
   localparam logic [1:0] c_RGN_OPEN = 2'd2;
   localparam logic [1:0] c_RGN_CART = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   state_t                  r_state;
   logic [c_CNT_W-1:0]      r_cnt;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic                    r_we;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic [1:0]              r_rgn;
   logic [DATA_WIDTH-1:0]   r_mem [0:c_RAM_DEPTH-1];

   logic [1:0]              w_rgn;
   logic [c_CNT_W-1:0]      w_wait;
   logic                    w_done;
   logic [c_RAM_AW-1:0]     w_ram_idx;
   logic                    w_ram_wr;

   // Region is taken from the top three address bits (8 KB granules).
   always_comb begin
      w_rgn  = c_RGN_CART;
      w_wait = c_CART_WAIT;
      unique case (addr_in[ADDR_WIDTH-1 -: 3])
         3'b000: begin
            w_rgn  = c_RGN_RAM;
            w_wait = c_RAM_WAIT;
         end
         3'b001: begin
            w_rgn  = c_RGN_IO;
            w_wait = c_IO_WAIT;
         end
         3'b010: begin
            w_rgn  = c_RGN_OPEN;
            w_wait = '0;
         end
         default: begin
            w_rgn  = c_RGN_CART;
            w_wait = c_CART_WAIT;
         end
      endcase
   end

   assign w_done    = (r_state == ST_WAIT) && (r_cnt == '0);
   assign w_ram_idx = r_addr[c_RAM_AW-1:0];
   assign w_ram_wr  = w_done && (r_rgn == c_RGN_RAM) && r_we;

   assign io_addr    = r_addr[2:0];
   assign io_wdata   = r_wdata;
   assign cart_addr  = r_addr;
   assign cart_wdata = r_wdata;

   // Work RAM has no reset; writes happen only on the completing edge.
   always_ff @(posedge clk) begin
      if (w_ram_wr) begin
         r_mem[w_ram_idx] <= r_wdata;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_addr   <= '0;
         r_we     <= 1'b0;
         r_wdata  <= '0;
         r_rgn    <= c_RGN_RAM;
         rdata    <= '0;
         ack      <= 1'b0;
         busy     <= 1'b0;
         io_sel   <= 1'b0;
         io_we    <= 1'b0;
         cart_sel <= 1'b0;
         cart_we  <= 1'b0;
      end else begin
         ack <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (req) begin
                  r_addr   <= addr_in;
                  r_we     <= we;
                  r_wdata  <= wdata;
                  r_rgn    <= w_rgn;
                  r_cnt    <= w_wait;
                  r_state  <= ST_WAIT;
                  busy     <= 1'b1;
                  io_sel   <= (w_rgn == c_RGN_IO);
                  io_we    <= (w_rgn == c_RGN_IO) && we;
                  cart_sel <= (w_rgn == c_RGN_CART);
                  cart_we  <= (w_rgn == c_RGN_CART) && we;
               end
            end
            ST_WAIT: begin
               if (r_cnt == '0) begin
                  r_state  <= ST_ACK;
                  ack      <= 1'b1;
                  io_sel   <= 1'b0;
                  io_we    <= 1'b0;
                  cart_sel <= 1'b0;
                  cart_we  <= 1'b0;
                  // Writes and open-bus reads keep the last driven value.
                  if (!r_we) begin
                     unique case (r_rgn)
                        c_RGN_RAM:  rdata <= r_mem[w_ram_idx];
                        c_RGN_IO:   rdata <= io_rdata;
                        c_RGN_CART: rdata <= cart_rdata;
                        default:    rdata <= rdata;
                     endcase
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            ST_ACK: begin
               r_state <= ST_IDLE;
               busy    <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: doc/addr_bus_responder.md
Name: addr_bus_responder

Overview:
- Target-side consumer of the CPU address bus: takes the 16-bit address chosen by the address bus mux, plus a request/write qualifier and write data.
- Decodes the address into NES-style regions: internal 2 KB work RAM with mirroring, mirrored 8-register I/O window, open bus, and cartridge space.
- Applies a per-region wait-state count, then completes the access with a one-cycle ack and registered read data.
- Sits between the address/data buses and the memory/peripheral side of the design.

Parameters:
ADDR_WIDTH, 16, address bus width (`ADDR_WIDTH)
DATA_WIDTH, 8, data bus width
RAM_WAIT, 0, wait cycles for the internal RAM region
IO_WAIT, 2, wait cycles for the I/O region
CART_WAIT, 1, wait cycles for the cartridge region

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
addr_in  in  ADDR_WIDTH  address from the address bus output
req  in  1  access request (level)
we  in  1  1 = write, 0 = read; sampled with req
wdata  in  DATA_WIDTH  write data; sampled with req
rdata  out  DATA_WIDTH  read data; valid while ack = 1, then held
ack  out  1  one-cycle transaction completion
busy  out  1  high in any state other than IDLE
io_sel  out  1  I/O region access in progress
io_addr  out  3  I/O register index (addr[2:0])
io_we  out  1  I/O write strobe
io_wdata  out  DATA_WIDTH  I/O write data
io_rdata  in  DATA_WIDTH  I/O read data
cart_sel  out  1  cartridge access in progress
cart_addr  out  ADDR_WIDTH  full latched address
cart_we  out  1  cartridge write strobe
cart_wdata  out  DATA_WIDTH  cartridge write data
cart_rdata  in  DATA_WIDTH  cartridge read data

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (reset_n).
- Reset values: state = IDLE; rdata = 0x00; ack, busy, io_sel, io_we, cart_sel, cart_we = 0; io_addr = 0; cart_addr = 0; io_wdata, cart_wdata = 0. RAM contents are not reset.
- Region decode on latched addr:
  - 0x0000–0x1FFF: RAM, index = addr[10:0] (4x mirror).
  - 0x2000–0x3FFF: IO, io_addr = addr[2:0] (mirrored every 8 bytes).
  - 0x4000–0x5FFF: OPEN bus.
  - 0x6000–0xFFFF: CART.
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - If req = 1 at a rising edge: latch addr, we, wdata and region.
  - Load the counter with the region wait (OPEN uses 0).
  - Next state is WAIT.
- WAIT:
  - If counter = 0, next state is ACK; otherwise decrement.
  - req, addr_in, we and wdata are ignored while in WAIT.
- Completion, on the WAIT→ACK edge:
  - RAM read: rdata ← ram[index].
  - RAM write: ram[index] ← wdata.
  - IO read: rdata ← io_rdata.
  - CART read: rdata ← cart_rdata.
  - OPEN read: rdata unchanged, so the last driven value is returned.
  - All writes leave rdata unchanged. OPEN writes are dropped.
- ACK:
  - ack = 1 for exactly one cycle.
  - Next state is always IDLE; req is not accepted in ACK.
- Latency: acceptance edge k gives ack high in the cycle following edge k+1+W. With W=0, ack is seen 2 edges after the req sample.
- Back-to-back requests: a req held high is re-accepted in IDLE, so one transaction occurs every W+3 cycles.
- Peripheral strobes:
  - io_sel / cart_sel are high for the whole WAIT state of the matching region, low in ACK.
  - io_we / cart_we equal the latched we while the matching sel is high.
  - io_wdata / cart_wdata hold the latched wdata.
  - Peripherals must present read data by the last WAIT cycle.
- busy = 1 in WAIT and ACK.
- Reset mid-transaction: return to IDLE immediately and drop all strobes. No RAM write occurs if reset asserts before the WAIT→ACK edge. No ack is produced.
- Simultaneous events: req high during a reset release edge is not accepted on that edge.

Test Plan:
- RAM write/read with mirror:
  - Write 0x0123 = 0xA5 → ack 2 edges after acceptance.
  - Read 0x0923 → rdata = 0xA5 with ack.
  - Read 0x1923 → 0xA5.
- IO read with mirroring (IO_WAIT=2):
  - Read 0x3FFA with io_rdata = 0x3C → io_addr = 2 and io_sel high 3 cycles, io_we = 0.
  - ack on the 4th cycle after acceptance, rdata = 0x3C.
- IO write: write 0x2007 = 0x5E → io_we = 1 and io_wdata = 0x5E during io_sel; rdata unchanged.
- Open bus: after a cart read returning 0x77, read 0x4500 → rdata = 0x77 with ack; write 0x5000 = 0x11 → no strobes, rdata still 0x77.
- Reset mid-wait: start RAM write 0x0010 = 0xFF, assert reset_n = 0 in WAIT → outputs return to reset values; a subsequent read of 0x0010 does not return 0xFF (preload RAM = 0x00 → rdata = 0x00).
- Back-to-back: hold req = 1 reading cart 0x8000, 0x8001 (CART_WAIT=1) → ack every 4 cycles; addresses change while busy are ignored; cart_addr matches the latched values.
